// File: rtl/serial_addsub_pkg.sv
// Package for serial_addsub: state type and default parameters from the shared defs file.
package serial_addsub_pkg;

`include "serial_addsub_defs.vh"

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_BUSY = ST_BUSY_ENC,
    ST_DONE = ST_DONE_ENC
  } state_t;

endpackage

// File: rtl/serial_addsub_defs.vh
// Shared constants for serial_addsub: FSM state encodings and default geometry.
`ifndef SERIAL_ADDSUB_DEFS_VH
`define SERIAL_ADDSUB_DEFS_VH

localparam logic [1:0]  ST_IDLE_ENC = 2'd0;
localparam logic [1:0]  ST_BUSY_ENC = 2'd1;
localparam logic [1:0]  ST_DONE_ENC = 2'd2;

localparam int unsigned DEF_WIDTH   = 8;
localparam int unsigned DEF_DIGIT   = 2;

`endif

// File: rtl/serial_addsub_digit.sv
// addsub_digit: combinational DIGIT-bit ripple adder with carry in and carry out.
module addsub_digit #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout
);

  assign {o_cout, o_sum} = (DIGIT+1)'(i_a) + (DIGIT+1)'(i_b) + (DIGIT+1)'(i_cin);

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial two's complement adder/subtractor, DIGIT bits per cycle, LSB slice first.
// Optional result saturation on signed overflow when SERIAL_ADDSUB_SAT_EN is defined.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int unsigned L     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(L - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;

  logic             w_accept;
  logic             w_last;
  logic [IDX_W-1:0] w_base;
  logic [DIGIT-1:0] w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_s_final;
  logic             w_v;

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_state == ST_BUSY) && (r_cnt == LAST);
  assign w_base   = IDX_W'(r_cnt * DIGIT);

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .i_a    (r_a[w_base +: DIGIT]),
    .i_b    (r_b[w_base +: DIGIT]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Partial result with the current slice merged in; complete on the last slice.
  always_comb begin
    w_res                  = r_acc;
    w_res[w_base +: DIGIT] = w_sum;
  end

  assign w_v = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);

`ifdef SERIAL_ADDSUB_SAT_EN
  // On overflow the true result has the sign of the (equal-signed) operands.
  always_comb begin
    w_s_final = w_res;
    if (w_v) begin
      w_s_final = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_s_final = w_res;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: w_state_nxt = start ? ST_BUSY : ST_IDLE;
      ST_BUSY:          if (r_cnt == LAST) w_state_nxt = ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered status; B is stored already inverted for subtract.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      S       <= '0;
      Cout    <= 1'b0;
      V       <= 1'b0;
    end else begin
      busy <= (r_state == ST_BUSY);
      done <= (r_state == ST_DONE);
      if (w_accept) begin
        r_a     <= A;
        r_b     <= B ^ {WIDTH{sel}};
        r_carry <= sel;
        r_cnt   <= '0;
        r_acc   <= '0;
      end else if (r_state == ST_BUSY) begin
        r_acc   <= w_res;
        r_carry <= w_cout;
        r_cnt   <= r_cnt + CNT_W'(1);
        if (w_last) begin
          S    <= w_s_final;
          Cout <= w_cout;
          V    <= w_v;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub at WIDTH=8, DIGIT=2.
module tb_serial_addsub;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIGIT = 2;

`ifdef SERIAL_ADDSUB_SAT_EN
  localparam logic [7:0] EXP_7F_PLUS_01 = 8'h7F;
  localparam logic [7:0] EXP_80_MINUS_01 = 8'h80;
  localparam logic [7:0] EXP_80_PLUS_80 = 8'h80;
`else
  localparam logic [7:0] EXP_7F_PLUS_01 = 8'h80;
  localparam logic [7:0] EXP_80_MINUS_01 = 8'h7F;
  localparam logic [7:0] EXP_80_PLUS_80 = 8'h00;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             sel;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;

  int n_checks = 0;
  int n_fail   = 0;

  serial_addsub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sel   (sel),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout),
    .V     (V)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation, scramble inputs after acceptance, wait (bounded) for done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; A = a; B = b; sel = s;
    @(posedge clk); #1;
    start = 1'b0; A = 8'($urandom); B = 8'($urandom); sel = 1'($urandom);
    lat = 0; bcnt = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic check_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [7:0] exp_s, input logic exp_c,
                          input logic exp_v);
    int lat;
    int bcnt;
    run_op(a, b, s, lat, bcnt);
    check({tag, "_lat"}, 64'(lat), 64'd5);
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'd4);
    check({tag, "_s"}, 64'(S), 64'(exp_s));
    check({tag, "_cout"}, 64'(Cout), 64'(exp_c));
    check({tag, "_v"}, 64'(V), 64'(exp_v));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_s_hold"}, 64'(S), 64'(exp_s));
  endtask

  initial begin
    int lat;
    int bcnt;
    int ndone;
    logic [7:0] s_seen;
    logic c_seen;

    // Reset with start asserted: must be ignored.
    rst_n = 1'b0; start = 1'b1; sel = 1'b0; A = 8'h55; B = 8'h22;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_s", 64'(S), 64'd0);
    check("rst_cout", 64'(Cout), 64'd0);
    check("rst_v", 64'(V), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle", 64'(busy), 64'd0);

    check_op("add_01_02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    check_op("sub_01_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0);
    check_op("add_7f_01", 8'h7F, 8'h01, 1'b0, EXP_7F_PLUS_01, 1'b0, 1'b1);
    check_op("sub_80_01", 8'h80, 8'h01, 1'b1, EXP_80_MINUS_01, 1'b1, 1'b1);
    check_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    check_op("add_80_80", 8'h80, 8'h80, 1'b0, EXP_80_PLUS_80, 1'b1, 1'b1);
    check_op("sub_5a_5a", 8'h5A, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);

    // Start re-pulsed during BUSY with different operands must be ignored.
    @(negedge clk);
    start = 1'b1; A = 8'h06; B = 8'h04; sel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = 8'h00; B = 8'h00; sel = 1'b0;
    @(negedge clk);
    start = 1'b1; A = 8'hFF; B = 8'h01; sel = 1'b0;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; s_seen = 8'h00; c_seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        s_seen = S;
        c_seen = Cout;
      end
    end
    check("busy_restart_done_count", 64'(ndone), 64'd1);
    check("busy_restart_s", 64'(s_seen), 64'h02);
    check("busy_restart_cout", 64'(c_seen), 64'd1);

    // Reset sampled in the second BUSY cycle aborts the operation.
    @(negedge clk);
    start = 1'b1; A = 8'h11; B = 8'h22; sel = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_s", 64'(S), 64'd0);
    check("abort_cout", 64'(Cout), 64'd0);
    check("abort_v", 64'(V), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0; bcnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (busy) bcnt++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    check("abort_stays_idle", 64'(bcnt), 64'd0);

    // Start held high through DONE: second operation follows with no IDLE cycle.
    @(negedge clk);
    start = 1'b1; A = 8'h10; B = 8'h20; sel = 1'b0;
    @(posedge clk); #1;
    A = 8'h05; B = 8'h03; sel = 1'b1;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_first_lat", 64'(lat), 64'd5);
    check("b2b_first_s", 64'(S), 64'h30);
    check("b2b_first_cout", 64'(Cout), 64'd0);
    start = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 20);
    check("b2b_gap", 64'(lat), 64'd5);
    check("b2b_second_s", 64'(S), 64'h02);
    check("b2b_second_cout", 64'(Cout), 64'd1);
    check("b2b_second_v", 64'(V), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal: 4..64).
REQ-002 SHALL have parameter DIGIT, default 2, meaning bits processed per cycle (legal: WIDTH mod DIGIT == 0).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request an operation; operands captured when accepted.
REQ-006 SHALL have port sel  input  1  0 = A+B, 1 = A-B; captured with operands.
REQ-007 SHALL have port A  input  WIDTH  first operand, two's complement.
REQ-008 SHALL have port B  input  WIDTH  second operand, two's complement.
REQ-009 SHALL have port busy  output  1  high while digits are being processed.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port S  output  WIDTH  result.
REQ-012 SHALL have port Cout  output  1  unsigned carry out of MSB; on subtract, 1 = no borrow.
REQ-013 SHALL have port V  output  1  signed overflow.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; L = WIDTH/DIGIT.
- IDLE: start=1 -> capture A, B, sel; clear digit counter; carry-in = sel; go to BUSY.
- BUSY: each cycle add one DIGIT slice of A and (B XOR {sel}), LSB slice first; ripple carry into a carry register; after the L-th slice go to DONE.
- DONE: done=1 for exactly one cycle; start=1 here is accepted as in IDLE (back-to-back); otherwise go to IDLE.
REQ-015 SHALL assert done exactly L+1 rising edges after the edge that accepted start.
REQ-016 SHALL hold busy=1 only in BUSY.
REQ-017 SHALL ignore start while in BUSY: no operand recapture and no effect on the current result.
REQ-018 SHALL leave the A, B, and sel inputs don't-care after the accepting edge.
REQ-019 SHALL make S, Cout, and V valid when done=1, and SHALL hold them unchanged until the next accepted start completes.
REQ-020 SHALL compute V = (MSB of A == MSB of effective B) AND (MSB of S != MSB of A), where effective B = B XOR {sel}.
REQ-021 SHALL wrap results modulo 2^WIDTH when SAT_EN is undefined.

Reset
REQ-022 SHALL, when rst_n=0 at an edge, force the state to IDLE and set busy=0, done=0, S=0, Cout=0, V=0, and the counter to 0.
REQ-023 SHALL abort an operation on reset mid-operation, with no done pulse for it.
REQ-024 SHALL ignore start during the reset cycle.

Configuration
REQ-025 SHALL support macro SERIAL_ADDSUB_SAT_EN:
- Defined: on V=1, S saturates to 2^(WIDTH-1)-1 when the result should be positive, or to -2^(WIDTH-1) when it should be negative; V and Cout are reported unchanged.
- Undefined: no saturation logic is present; S wraps.

Structure
REQ-026 SHALL place the FSM state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) in shared include file serial_addsub_defs.vh.
REQ-027 SHALL place the default WIDTH and DIGIT constants in serial_addsub_defs.vh.
REQ-028 SHALL use one combinational sub-module, addsub_digit (DIGIT-bit ripple add with carry in/out), instantiated once.

Verification (WIDTH=8, DIGIT=2, L=4)
REQ-029 A=0x01, B=0x02, sel=0, start -> done 5 edges later; S=0x03, Cout=0, V=0; busy high for 4 cycles.
REQ-030 A=0x01, B=0x02, sel=1 -> S=0xFF, Cout=0, V=0.
REQ-031 A=0x7F, B=0x01, sel=0 -> S=0x80, V=1, Cout=0; with SAT_EN: S=0x7F, V=1.
REQ-032 A=0x80, B=0x01, sel=1 -> S=0x7F, Cout=1, V=1; with SAT_EN: S=0x80.
REQ-033 A=0x06, B=0x04, sel=1, start; re-pulse start with A=0xFF during BUSY -> S=0x02, Cout=1, exactly one done pulse.
REQ-034 Start op; rst_n=0 in the 2nd BUSY cycle -> next cycle state IDLE, all outputs 0, no done pulse.
REQ-035 Start held high through DONE -> second operation begins with no IDLE cycle; its done arrives 5 edges after the first done.
